// File: rtl/uart_tx_if.sv
// uart_tx_if: queue, configuration and serial-line signals of the UART transmitter
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_clk_en;
  logic                 parity_en;
  logic                 parity_odd;
  logic                 double_stop_bit;
  logic                 tx_queue_empty;
  logic [DATA_BITS-1:0] tx_queue_data;
  logic                 tx_queue_re;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;
  modport master (
    output tx_clk_en, parity_en, parity_odd, double_stop_bit, tx_queue_empty, tx_queue_data,
    input  tx_queue_re, tx, tx_busy, tx_done
  );
  modport slave (
    input  tx_clk_en, parity_en, parity_odd, double_stop_bit, tx_queue_empty, tx_queue_data,
    output tx_queue_re, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: oversampled UART transmitter pulling frames from a first-word-fall-through queue
module uart_tx_controller #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input logic      clk,
  input logic      reset,
  uart_tx_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP_1, TX_STOP_2} state_t;
  state_t               state, state_n;
  logic [TW-1:0]        tick;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] sh;
  logic                 p_en, p_bit, dstop, tx_r, tx_n, period_end, load, last_bit;
  assign period_end      = bus.tx_clk_en && tick == TW'(OVERSAMPLE - 1);
  assign last_bit        = bit_cnt == BW'(DATA_BITS - 1);
  assign load            = state == TX_IDLE && !bus.tx_queue_empty && !reset;
  assign bus.tx_queue_re = load;
  assign bus.tx          = tx_r;
  assign bus.tx_busy     = state != TX_IDLE;
  assign bus.tx_done     = period_end && (state == TX_STOP_2 || (state == TX_STOP_1 && !dstop));
  // sh already holds the next data bit in bit 0: it is shifted as each bit goes onto the line
  always_comb begin
    state_n = state;
    tx_n    = tx_r;
    case (state)
      TX_IDLE: if (load) begin
        state_n = TX_START;
        tx_n    = 1'b0;
      end
      TX_START: if (period_end) begin
        state_n = TX_DATA;
        tx_n    = sh[0];
      end
      TX_DATA: if (period_end) begin
        state_n = !last_bit ? TX_DATA : p_en ? TX_PARITY : TX_STOP_1;
        tx_n    = !last_bit ? sh[0] : p_en ? p_bit : 1'b1;
      end
      TX_PARITY: if (period_end) begin
        state_n = TX_STOP_1;
        tx_n    = 1'b1;
      end
      TX_STOP_1: if (period_end) state_n = dstop ? TX_STOP_2 : TX_IDLE;
      TX_STOP_2: if (period_end) state_n = TX_IDLE;
      default: begin
        state_n = TX_IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= TX_IDLE;
      tx_r    <= 1'b1;
      tick    <= '0;
      bit_cnt <= '0;
      sh      <= '0;
      p_en    <= 1'b0;
      p_bit   <= 1'b0;
      dstop   <= 1'b0;
    end else begin
      state <= state_n;
      tx_r  <= tx_n;
      if (load) begin
        sh      <= bus.tx_queue_data;
        p_en    <= bus.parity_en;
        p_bit   <= ^bus.tx_queue_data ^ bus.parity_odd;
        dstop   <= bus.double_stop_bit;
        tick    <= '0;
        bit_cnt <= '0;
      end else if (state != TX_IDLE && bus.tx_clk_en) begin
        tick <= period_end ? '0 : tick + 1'b1;
        if (period_end && (state == TX_START || state == TX_DATA)) sh <= sh >> 1;
        if (period_end && state == TX_DATA) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
endmodule
